// File: rtl/pipelined_barrel_shifter_if.sv
// Handshake bundle for pipelined_barrel_shifter: operand/ctrl/tag in, result/tag/zero out.
interface pipelined_barrel_shifter_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 5
);
    localparam int unsigned SHAMT_W = $clog2(WIDTH);

    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   data_input;
    logic [SHAMT_W-1:0] ctrl_shiftamt;
    logic [1:0]         ctrl_shiftop;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   data_result;
    logic [TAG_W-1:0]   out_tag;
    logic               out_zero;

    modport master (
        output in_valid, data_input, ctrl_shiftamt, ctrl_shiftop, in_tag, out_ready,
        input  in_ready, out_valid, data_result, out_tag, out_zero
    );

    modport slave (
        input  in_valid, data_input, ctrl_shiftamt, ctrl_shiftop, in_tag, out_ready,
        output in_ready, out_valid, data_result, out_tag, out_zero
    );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined SLL/SRL/SRA barrel shifter, one stage per shift-amount bit, valid/ready at both ends.
// Define SHIFTER_ROTATE_EN to make op 2'b11 a rotate right; otherwise 2'b11 passes data through.
module pipelined_barrel_shifter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 5
) (
    input logic                        clock,
    input logic                        reset,
    pipelined_barrel_shifter_if.slave  bus
);
    localparam int unsigned SHAMT_W = $clog2(WIDTH);
    localparam int unsigned LAST    = SHAMT_W - 1;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } shift_op_e;

    logic [WIDTH-1:0]   data_q  [SHAMT_W];
    logic [TAG_W-1:0]   tag_q   [SHAMT_W];
    shift_op_e          op_q    [SHAMT_W];
    logic [SHAMT_W-1:0] shamt_q [SHAMT_W];
    logic               sign_q  [SHAMT_W];
    logic [SHAMT_W-1:0] valid_q;
    logic [SHAMT_W-1:0] adv;

    logic [WIDTH-1:0]   src_data  [SHAMT_W];
    logic [TAG_W-1:0]   src_tag   [SHAMT_W];
    shift_op_e          src_op    [SHAMT_W];
    logic [SHAMT_W-1:0] src_shamt [SHAMT_W];
    logic               src_sign  [SHAMT_W];
    logic               src_valid [SHAMT_W];
    logic [WIDTH-1:0]   nxt_data  [SHAMT_W];

    // SRA fill comes from the sign captured at S0, not the current MSB of the partial result.
    function automatic logic [WIDTH-1:0] shift_step(
        input logic [WIDTH-1:0] d,
        input shift_op_e        op,
        input logic             sign,
        input int unsigned      amt
    );
        logic [WIDTH-1:0] ones;
        logic [WIDTH-1:0] fill;
        ones = '1;
        fill = sign ? ~(ones >> amt) : '0;
        case (op)
            OP_SLL:  shift_step = d << amt;
            OP_SRL:  shift_step = d >> amt;
            OP_SRA:  shift_step = fill | (d >> amt);
`ifdef SHIFTER_ROTATE_EN
            OP_ROR:  shift_step = (d >> amt) | (d << (WIDTH - amt));
`else
            OP_ROR:  shift_step = d;
`endif
            default: shift_step = d;
        endcase
    endfunction

    always_comb begin
        src_valid[0] = bus.in_valid;
        src_data[0]  = bus.data_input;
        src_tag[0]   = bus.in_tag;
        src_op[0]    = shift_op_e'(bus.ctrl_shiftop);
        src_shamt[0] = bus.ctrl_shiftamt;
        src_sign[0]  = bus.data_input[WIDTH-1];
        for (int unsigned k = 1; k < SHAMT_W; k++) begin
            src_valid[k] = valid_q[k-1];
            src_data[k]  = data_q[k-1];
            src_tag[k]   = tag_q[k-1];
            src_op[k]    = op_q[k-1];
            src_shamt[k] = shamt_q[k-1];
            src_sign[k]  = sign_q[k-1];
        end
        for (int unsigned k = 0; k < SHAMT_W; k++) begin
            nxt_data[k] = src_shamt[k][k]
                        ? shift_step(src_data[k], src_op[k], src_sign[k], 32'd1 << k)
                        : src_data[k];
        end
    end

    // Ready ripples from the output back to S0 so empty stages fill behind a stall.
    always_comb begin
        adv       = '0;
        adv[LAST] = bus.out_ready || !valid_q[LAST];
        for (int unsigned i = 1; i < SHAMT_W; i++) begin
            adv[LAST-i] = !valid_q[LAST-i] || adv[LAST-i+1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            for (int unsigned k = 0; k < SHAMT_W; k++) begin
                data_q[k]  <= '0;
                tag_q[k]   <= '0;
                op_q[k]    <= OP_SLL;
                shamt_q[k] <= '0;
                sign_q[k]  <= 1'b0;
            end
        end else begin
            for (int unsigned k = 0; k < SHAMT_W; k++) begin
                if (adv[k]) begin
                    valid_q[k] <= src_valid[k];
                    if (src_valid[k]) begin
                        data_q[k]  <= nxt_data[k];
                        tag_q[k]   <= src_tag[k];
                        op_q[k]    <= src_op[k];
                        shamt_q[k] <= src_shamt[k];
                        sign_q[k]  <= src_sign[k];
                    end
                end
            end
        end
    end

    assign bus.in_ready    = adv[0];
    assign bus.out_valid   = valid_q[LAST];
    assign bus.data_result = data_q[LAST];
    assign bus.out_tag     = tag_q[LAST];
    assign bus.out_zero    = valid_q[LAST] && (data_q[LAST] == '0);
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Randomised and directed bench for pipelined_barrel_shifter against an occupancy/queue reference model.
module tb_pipelined_barrel_shifter;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned TAG_W = 5;
    localparam int unsigned DEPTH = 5;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    pipelined_barrel_shifter_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

    pipelined_barrel_shifter #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned now      = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, now);
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input int unsigned amt,
                                              input int unsigned op);
`ifdef SHIFTER_ROTATE_EN
        logic [63:0] dd;
`endif
        case (op)
            0: return d << amt;
            1: return d >> amt;
            2: return $signed(d) >>> amt;
            default: begin
`ifdef SHIFTER_ROTATE_EN
                dd = {d, d} >> amt;
                return dd[31:0];
`else
                return d;
`endif
            end
        endcase
    endfunction

    // One clock: drive at negedge, sample 1ns later, update the model for the coming edge.
    task automatic cycle(input logic rst, input logic v, input logic [31:0] d, input int unsigned amt,
                         input int unsigned op, input logic [4:0] tag, input logic ordy);
        exp_t e;
        logic exp_rdy;
        @(negedge clock);
        reset             = rst;
        bus.in_valid      = v;
        bus.data_input    = d;
        bus.ctrl_shiftamt = amt[4:0];
        bus.ctrl_shiftop  = op[1:0];
        bus.in_tag        = tag;
        bus.out_ready     = ordy;
        #1;
        now++;
        if (rst) begin
            sb.delete();
            return;
        end
        exp_rdy = ordy || (sb.size() < DEPTH);
        check_eq("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
        if (sb.size() > 0 && (now - sb[0].cyc) >= DEPTH) begin
            check_eq("out_valid", {31'd0, bus.out_valid}, 32'd1);
            check_eq("data_result", bus.data_result, sb[0].data);
            check_eq("out_tag", {27'd0, bus.out_tag}, {27'd0, sb[0].tag});
            check_eq("out_zero", {31'd0, bus.out_zero}, {31'd0, (sb[0].data == 32'd0)});
            if (ordy) void'(sb.pop_front());
        end else begin
            check_eq("out_valid", {31'd0, bus.out_valid}, 32'd0);
        end
        if (v && exp_rdy) begin
            e.data = ref_shift(d, amt, op);
            e.tag  = tag;
            e.cyc  = now;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, 1'b0, $urandom, $urandom_range(0, 31), $urandom_range(0, 3),
              5'($urandom_range(0, 31)), ordy);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() > 0; i++) idle(1'b1);
        check_eq("drain_timeout", sb.size(), 32'd0);
    endtask

    task automatic check_cleared(input string tag);
        check_eq({tag, "_data"}, bus.data_result, 32'd0);
        check_eq({tag, "_tag"}, {27'd0, bus.out_tag}, 32'd0);
        check_eq({tag, "_zero"}, {31'd0, bus.out_zero}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned amt;
        int unsigned r;
        logic [31:0] d;

        bus.in_valid      = 1'b0;
        bus.data_input    = '0;
        bus.ctrl_shiftamt = '0;
        bus.ctrl_shiftop  = '0;
        bus.in_tag        = '0;
        bus.out_ready     = 1'b0;

        repeat (3) cycle(1'b1, 1'b0, 32'd0, 0, 0, 5'd0, 1'b0);
        idle(1'b0);
        check_cleared("reset");

        cycle(1'b0, 1'b1, 32'h0000_0001, 31, 0, 5'h13, 1'b1);
        drain();

        cycle(1'b0, 1'b1, 32'h8000_0000, 4, 2, 5'h01, 1'b1);
        cycle(1'b0, 1'b1, 32'h8000_0000, 4, 1, 5'h02, 1'b1);
        drain();

        cycle(1'b0, 1'b1, 32'h0000_0000, 7, 0, 5'h03, 1'b1);
        cycle(1'b0, 1'b1, 32'h1234_5678, 0, 1, 5'h04, 1'b1);
        drain();

        cycle(1'b0, 1'b1, 32'h0000_00F1, 4, 3, 5'h05, 1'b1);
        cycle(1'b0, 1'b1, 32'h8000_0001, 31, 2, 5'h06, 1'b1);
        cycle(1'b0, 1'b1, 32'h8000_0001, 31, 1, 5'h07, 1'b1);
        drain();

        for (int i = 0; i < 5; i++)
            cycle(1'b0, 1'b1, $urandom, $urandom_range(0, 31), $urandom_range(0, 3), 5'(8 + i), 1'b1);
        for (int i = 0; i < 6; i++)
            cycle(1'b0, 1'b1, $urandom, $urandom_range(0, 31), $urandom_range(0, 3), 5'(20 + i), 1'b0);
        drain();

        for (int i = 0; i < 3000; i++) begin
            r   = $urandom_range(0, 9);
            amt = (r == 0) ? 0 : (r == 1) ? 31 : $urandom_range(0, 31);
            d   = ($urandom_range(0, 15) == 0) ? 32'd0 : $urandom;
            cycle(1'b0, ($urandom_range(0, 3) != 0), d, amt, $urandom_range(0, 3),
                  5'($urandom_range(0, 31)), ($urandom_range(0, 3) != 0));
        end
        drain();

        for (int i = 0; i < 3; i++)
            cycle(1'b0, 1'b1, $urandom | 32'h1, $urandom_range(0, 31), $urandom_range(0, 3), 5'(i + 1), 1'b1);
        cycle(1'b1, 1'b0, 32'd0, 0, 0, 5'd0, 1'b1);
        idle(1'b1);
        check_cleared("midflight_reset");
        repeat (10) idle(1'b1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
